rib_arbiter: RTL and testbench

RIB_ARBITER -- requirements
Module: rib_arbiter

---
 rtl/rib_arbiter_pkg.sv | 17 +
 rtl/rib_arbiter_gen_en_dff.sv | 28 ++
 rtl/rib_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_rib_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rib_arbiter_pkg.sv
// rib_arbiter_pkg
// Shared definitions for the RIB two-master arbiter: FSM state encodings
// and the default starvation limit for the instruction-fetch master.
package rib_arbiter_pkg;

  // IDLE grants and launches requests; WAIT_Mx holds the bus for master x
  // until its response handshake completes.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_M0 = 2'd1,
    ST_WAIT_M1 = 2'd2
  } state_t;

  // Maximum consecutive m0 grants while m1 waits before m1 is forced through.
  localparam int unsigned DEFAULT_STARVE_LIMIT = 8;

endpackage

// File: rtl/rib_arbiter_gen_en_dff.sv
// rib_arbiter_gen_en_dff
// Generic enabled D flop with asynchronous active-low reset to a constant.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, loads RESET_VAL
//   en    - load enable
//   d     - next value
//   q     - registered value
module rib_arbiter_gen_en_dff #(
  parameter int unsigned            WIDTH     = 1,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rib_arbiter.sv
// rib_arbiter
// Arbitrates two RIB masters (m0 = load/store unit, m1 = instruction fetch)
// onto a single slave with at most one outstanding transaction. m0 has
// priority unless m1 has been passed over STARVE_LIMIT times in a row.
// Ports:
//   clk, rst_n                    - clock, async active-low reset
//   mX_addr/data/sel/we_i         - master X request payload
//   mX_req_valid_i/mX_req_ready_o - master X request handshake
//   mX_data_o, mX_rsp_valid_o,
//   mX_rsp_ready_i                - master X response
//   s_addr/data/sel/we_o,
//   s_req_valid_o/s_req_ready_i   - shared slave request
//   s_data_i, s_rsp_valid_i,
//   s_rsp_ready_o                 - shared slave response
//   m1_hold_o                     - m1 is requesting but not being accepted
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m0_we_i,
  input  logic        m1_we_i,
  input  logic        m0_req_valid_i,
  input  logic        m1_req_valid_i,
  output logic        m0_req_ready_o,
  output logic        m1_req_ready_o,
  output logic [31:0] m0_data_o,
  output logic [31:0] m1_data_o,
  output logic        m0_rsp_valid_o,
  output logic        m1_rsp_valid_o,
  input  logic        m0_rsp_ready_i,
  input  logic        m1_rsp_ready_i,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_req_valid_o,
  input  logic        s_req_ready_i,
  input  logic [31:0] s_data_i,
  input  logic        s_rsp_valid_i,
  output logic        s_rsp_ready_o,
  output logic        m1_hold_o
);

  localparam int unsigned    CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

  logic [1:0]    state_raw;
  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] cnt_d;
  logic          cnt_en;

  logic forced;
  logic grant_m0, grant_m1;
  logic owner_m0, owner_m1;
  logic m0_req_hs, m1_req_hs;
  logic req_hs, rsp_hs;

  assign state_q = state_t'(state_raw);

  // Grant and ownership. Everything is qualified by rst_n so that all
  // outputs are forced low while reset is asserted, regardless of inputs.
  always_comb begin
    forced   = (starve_cnt == LIMIT) && m1_req_valid_i;
    grant_m0 = 1'b0;
    grant_m1 = 1'b0;
    if (rst_n && state_q == ST_IDLE) begin
      grant_m0 = m0_req_valid_i && !forced;
      grant_m1 = !grant_m0 && m1_req_valid_i;
    end
    owner_m0 = grant_m0 || (rst_n && state_q == ST_WAIT_M0);
    owner_m1 = grant_m1 || (rst_n && state_q == ST_WAIT_M1);
  end

  // Request path: the granted master drives the slave; ungranted sees ready 0.
  always_comb begin
    s_addr_o       = '0;
    s_data_o       = '0;
    s_sel_o        = '0;
    s_we_o         = 1'b0;
    s_req_valid_o  = 1'b0;
    m0_req_ready_o = 1'b0;
    m1_req_ready_o = 1'b0;
    if (grant_m0) begin
      s_addr_o       = m0_addr_i;
      s_data_o       = m0_data_i;
      s_sel_o        = m0_sel_i;
      s_we_o         = m0_we_i;
      s_req_valid_o  = m0_req_valid_i;
      m0_req_ready_o = s_req_ready_i;
    end else if (grant_m1) begin
      s_addr_o       = m1_addr_i;
      s_data_o       = m1_data_i;
      s_sel_o        = m1_sel_i;
      s_we_o         = m1_we_i;
      s_req_valid_o  = m1_req_valid_i;
      m1_req_ready_o = s_req_ready_i;
    end
  end

  // Response path: only the owner sees the response. With no owner the
  // response is accepted and dropped, which also flushes a transaction
  // orphaned by a mid-flight reset.
  always_comb begin
    m0_data_o      = '0;
    m1_data_o      = '0;
    m0_rsp_valid_o = 1'b0;
    m1_rsp_valid_o = 1'b0;
    s_rsp_ready_o  = 1'b1;
    if (owner_m0) begin
      m0_data_o      = s_data_i;
      m0_rsp_valid_o = s_rsp_valid_i;
      s_rsp_ready_o  = m0_rsp_ready_i;
    end else if (owner_m1) begin
      m1_data_o      = s_data_i;
      m1_rsp_valid_o = s_rsp_valid_i;
      s_rsp_ready_o  = m1_rsp_ready_i;
    end
  end

  assign m1_hold_o = rst_n && m1_req_valid_i && !m1_req_ready_o;

  assign m0_req_hs = m0_req_valid_i && m0_req_ready_o;
  assign m1_req_hs = m1_req_valid_i && m1_req_ready_o;
  assign req_hs    = s_req_valid_o && s_req_ready_i;
  assign rsp_hs    = s_rsp_valid_i && s_rsp_ready_o;

  // Next state. A request and response in the same cycle is a complete
  // single-cycle transaction, so IDLE is kept.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_hs && !rsp_hs) begin
          state_d = grant_m0 ? ST_WAIT_M0 : ST_WAIT_M1;
        end
      end
      ST_WAIT_M0, ST_WAIT_M1: begin
        if (rsp_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Starvation counter: counts m0 wins while m1 is waiting, saturating at
  // the limit; any m1 acceptance or m1 going idle restarts it.
  always_comb begin
    cnt_d  = starve_cnt;
    cnt_en = 1'b0;
    if (!m1_req_valid_i || m1_req_hs) begin
      cnt_d  = '0;
      cnt_en = 1'b1;
    end else if (m0_req_hs && starve_cnt != LIMIT) begin
      cnt_d  = starve_cnt + CW'(1);
      cnt_en = 1'b1;
    end
  end

  rib_arbiter_gen_en_dff #(
    .WIDTH    (2),
    .RESET_VAL(ST_IDLE)
  ) u_state_ff (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (1'b1),
    .d    (state_d),
    .q    (state_raw)
  );

  rib_arbiter_gen_en_dff #(
    .WIDTH    (CW),
    .RESET_VAL('0)
  ) u_starve_ff (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (cnt_en),
    .d    (cnt_d),
    .q    (starve_cnt)
  );

endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter
// Directed self-checking bench for rib_arbiter with default STARVE_LIMIT 8.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 3 time units after the edge.
module tb_rib_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] m0_addr_i, m1_addr_i, m0_data_i, m1_data_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m1_we_i;
  logic        m0_req_valid_i, m1_req_valid_i;
  logic        m0_req_ready_o, m1_req_ready_o;
  logic [31:0] m0_data_o, m1_data_o;
  logic        m0_rsp_valid_o, m1_rsp_valid_o;
  logic        m0_rsp_ready_i, m1_rsp_ready_i;
  logic [31:0] s_addr_o, s_data_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_req_valid_o, s_req_ready_i;
  logic [31:0] s_data_i;
  logic        s_rsp_valid_i, s_rsp_ready_o;
  logic        m1_hold_o;

  int checks;
  int failures;

  rib_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m0_addr_i     (m0_addr_i),
    .m1_addr_i     (m1_addr_i),
    .m0_data_i     (m0_data_i),
    .m1_data_i     (m1_data_i),
    .m0_sel_i      (m0_sel_i),
    .m1_sel_i      (m1_sel_i),
    .m0_we_i       (m0_we_i),
    .m1_we_i       (m1_we_i),
    .m0_req_valid_i(m0_req_valid_i),
    .m1_req_valid_i(m1_req_valid_i),
    .m0_req_ready_o(m0_req_ready_o),
    .m1_req_ready_o(m1_req_ready_o),
    .m0_data_o     (m0_data_o),
    .m1_data_o     (m1_data_o),
    .m0_rsp_valid_o(m0_rsp_valid_o),
    .m1_rsp_valid_o(m1_rsp_valid_o),
    .m0_rsp_ready_i(m0_rsp_ready_i),
    .m1_rsp_ready_i(m1_rsp_ready_i),
    .s_addr_o      (s_addr_o),
    .s_data_o      (s_data_o),
    .s_sel_o       (s_sel_o),
    .s_we_o        (s_we_o),
    .s_req_valid_o (s_req_valid_o),
    .s_req_ready_i (s_req_ready_i),
    .s_data_i      (s_data_i),
    .s_rsp_valid_i (s_rsp_valid_i),
    .s_rsp_ready_o (s_rsp_ready_o),
    .m1_hold_o     (m1_hold_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case the sequence below ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    m0_addr_i = '0; m1_addr_i = '0; m0_data_i = '0; m1_data_i = '0;
    m0_sel_i = '0; m1_sel_i = '0; m0_we_i = 1'b0; m1_we_i = 1'b0;
    m0_req_valid_i = 1'b0; m1_req_valid_i = 1'b0;
    m0_rsp_ready_i = 1'b0; m1_rsp_ready_i = 1'b0;
    s_req_ready_i = 1'b0; s_data_i = '0; s_rsp_valid_i = 1'b0;
  endtask

  // All outputs low during reset, apart from s_rsp_ready_o.
  task automatic test_reset;
    logic [7:0] ctl;
    rst_n = 1'b0;
    clear_inputs();
    m0_req_valid_i = 1'b1; m1_req_valid_i = 1'b1; s_req_ready_i = 1'b1;
    s_rsp_valid_i = 1'b1; m0_addr_i = 32'h1234; s_data_i = 32'hFFFF_FFFF;
    m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b1;
    #3;
    ctl = {m0_req_ready_o, m1_req_ready_o, s_req_valid_o, m1_hold_o,
           m0_rsp_valid_o, m1_rsp_valid_o, s_we_o, s_rsp_ready_o};
    checks++;
    if (ctl !== 8'b0000_0001) begin
      failures++;
      $display("[TB] FAIL reset_ctl got=%b exp=%b", ctl, 8'b0000_0001);
    end
    checks++;
    if ((s_addr_o | m0_data_o | m1_data_o) !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_data got=%h exp=0", s_addr_o | m0_data_o | m1_data_o);
    end
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // m1 alone against a single-cycle slave: one handshake per cycle.
  task automatic test_m1_only;
    logic [31:0] addr;
    for (int i = 0; i < 3; i++) begin
      addr = 32'(i * 4);
      m1_addr_i = addr; m1_req_valid_i = 1'b1; m1_rsp_ready_i = 1'b1;
      s_req_ready_i = 1'b1; s_rsp_valid_i = 1'b1; s_data_i = 32'hA000_0000 | addr;
      #2;
      checks++;
      if ({m1_req_ready_o, m1_hold_o, m1_rsp_valid_o, s_req_valid_o} !== 4'b1011) begin
        failures++;
        $display("[TB] FAIL m1_only_ctl[%0d] got=%b exp=1011", i,
                 {m1_req_ready_o, m1_hold_o, m1_rsp_valid_o, s_req_valid_o});
      end
      checks++;
      if (s_addr_o !== addr || m1_data_o !== (32'hA000_0000 | addr)) begin
        failures++;
        $display("[TB] FAIL m1_only_data[%0d] got=%h/%h exp=%h/%h", i, s_addr_o, m1_data_o,
                 addr, 32'hA000_0000 | addr);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  // Simultaneous requests: m0 first, m1 accepted right after m0's response.
  task automatic test_contention;
    m0_addr_i = 32'h2000_0000; m0_data_i = 32'hCAFE_0000; m0_sel_i = 4'hF; m0_we_i = 1'b1;
    m1_addr_i = 32'h0000_0100;
    m0_req_valid_i = 1'b1; m1_req_valid_i = 1'b1; s_req_ready_i = 1'b1;
    #2;
    checks++;
    if ({m0_req_ready_o, m1_req_ready_o, m1_hold_o} !== 3'b101) begin
      failures++;
      $display("[TB] FAIL contend_grant got=%b exp=101", {m0_req_ready_o, m1_req_ready_o, m1_hold_o});
    end
    checks++;
    if (s_addr_o !== 32'h2000_0000 || s_data_o !== 32'hCAFE_0000 || {s_we_o, s_sel_o} !== 5'h1F) begin
      failures++;
      $display("[TB] FAIL contend_payload got=%h/%h/%b exp=20000000/cafe0000/11111",
               s_addr_o, s_data_o, {s_we_o, s_sel_o});
    end
    tick();
    m0_req_valid_i = 1'b0; m0_we_i = 1'b0;
    s_rsp_valid_i = 1'b1; s_data_i = 32'h1234_5678; m0_rsp_ready_i = 1'b1;
    #2;
    checks++;
    if ({m1_req_ready_o, m1_hold_o, s_req_valid_o, m0_rsp_valid_o, m1_rsp_valid_o} !== 5'b01010) begin
      failures++;
      $display("[TB] FAIL contend_wait got=%b exp=01010",
               {m1_req_ready_o, m1_hold_o, s_req_valid_o, m0_rsp_valid_o, m1_rsp_valid_o});
    end
    checks++;
    if (m0_data_o !== 32'h1234_5678) begin
      failures++;
      $display("[TB] FAIL contend_m0_data got=%h exp=12345678", m0_data_o);
    end
    tick();
    m0_rsp_ready_i = 1'b0; m1_rsp_ready_i = 1'b1; s_data_i = 32'h0BAD_F00D;
    #2;
    checks++;
    if ({m1_req_ready_o, m1_hold_o, m0_rsp_valid_o, m1_rsp_valid_o} !== 4'b1001 ||
        s_addr_o !== 32'h0000_0100) begin
      failures++;
      $display("[TB] FAIL contend_m1_next got=%b/%h exp=1001/00000100",
               {m1_req_ready_o, m1_hold_o, m0_rsp_valid_o, m1_rsp_valid_o}, s_addr_o);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  // Slow slave: WAIT_M0 lasts three cycles, response routed to m0 only.
  task automatic test_slow_slave;
    m0_addr_i = 32'h40; m0_req_valid_i = 1'b1; s_req_ready_i = 1'b1;
    #2;
    checks++;
    if (m0_req_ready_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL slow_launch got=%b exp=1", m0_req_ready_o);
    end
    tick();
    m0_addr_i = 32'h44; m1_req_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        s_rsp_valid_i = 1'b1; s_data_i = 32'hDEAD_BEEF;
        m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b1;
      end
      #2;
      checks++;
      if ({m0_req_ready_o, m1_req_ready_o, s_req_valid_o, m1_hold_o} !== 4'b0001) begin
        failures++;
        $display("[TB] FAIL slow_wait[%0d] got=%b exp=0001", i,
                 {m0_req_ready_o, m1_req_ready_o, s_req_valid_o, m1_hold_o});
      end
      tick();
      if (i == 2) begin
        s_rsp_valid_i = 1'b0; s_data_i = '0;
      end
    end
    // Response cycle was checked above for ready; re-check routing explicitly.
    s_rsp_valid_i = 1'b0; s_req_ready_i = 1'b0;
    #2;
    checks++;
    if (s_addr_o !== 32'h44 || s_req_valid_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL slow_back_idle got=%h/%b exp=00000044/1", s_addr_o, s_req_valid_o);
    end
    clear_inputs();
    tick();
    // Repeat the wait, now observing the delivered response data.
    m0_addr_i = 32'h48; m0_req_valid_i = 1'b1; s_req_ready_i = 1'b1;
    tick();
    m0_req_valid_i = 1'b0; s_req_ready_i = 1'b0;
    tick();
    tick();
    s_rsp_valid_i = 1'b1; s_data_i = 32'hDEAD_BEEF; m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b1;
    #2;
    checks++;
    if ({m0_rsp_valid_o, m1_rsp_valid_o} !== 2'b10 || m0_data_o !== 32'hDEAD_BEEF ||
        m1_data_o !== 32'h0) begin
      failures++;
      $display("[TB] FAIL slow_route got=%b/%h/%h exp=10/deadbeef/00000000",
               {m0_rsp_valid_o, m1_rsp_valid_o}, m0_data_o, m1_data_o);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  // m0 dropping its request hands the grant to m1 without any side effect.
  task automatic test_deassert;
    m0_addr_i = 32'h300; m1_addr_i = 32'h400;
    m0_req_valid_i = 1'b1; m1_req_valid_i = 1'b1; s_req_ready_i = 1'b0;
    #2;
    checks++;
    if (s_addr_o !== 32'h300 || m1_hold_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL deassert_m0 got=%h/%b exp=00000300/1", s_addr_o, m1_hold_o);
    end
    tick();
    m0_req_valid_i = 1'b0;
    #2;
    checks++;
    if (s_addr_o !== 32'h400 || s_req_valid_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL deassert_m1 got=%h/%b exp=00000400/1", s_addr_o, s_req_valid_o);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  // Both masters saturating a single-cycle slave: 8 m0 grants then 1 m1.
  task automatic test_starvation;
    logic [1:0] exp_rdy;
    m0_req_valid_i = 1'b1; m1_req_valid_i = 1'b1; s_req_ready_i = 1'b1;
    s_rsp_valid_i = 1'b1; m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b1;
    for (int i = 0; i < 18; i++) begin
      exp_rdy = ((i % 9) == 8) ? 2'b01 : 2'b10;
      #2;
      checks++;
      if ({m0_req_ready_o, m1_req_ready_o} !== exp_rdy) begin
        failures++;
        $display("[TB] FAIL starve[%0d] got=%b exp=%b", i, {m0_req_ready_o, m1_req_ready_o}, exp_rdy);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  // Reset in WAIT_M1: outputs drop immediately, late response is discarded.
  task automatic test_reset_mid;
    m1_addr_i = 32'h80; m1_req_valid_i = 1'b1; s_req_ready_i = 1'b1;
    #2;
    checks++;
    if (m1_req_ready_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_launch got=%b exp=1", m1_req_ready_o);
    end
    tick();
    m0_req_valid_i = 1'b1;
    #2;
    checks++;
    if ({m0_req_ready_o, m1_req_ready_o, s_req_valid_o, m1_hold_o} !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL rstmid_wait got=%b exp=0001",
               {m0_req_ready_o, m1_req_ready_o, s_req_valid_o, m1_hold_o});
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m0_req_ready_o, m1_req_ready_o, s_req_valid_o, m1_hold_o, s_rsp_ready_o} !== 5'b00001 ||
        s_addr_o !== 32'h0) begin
      failures++;
      $display("[TB] FAIL rstmid_async got=%b/%h exp=00001/00000000",
               {m0_req_ready_o, m1_req_ready_o, s_req_valid_o, m1_hold_o, s_rsp_ready_o}, s_addr_o);
    end
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    s_rsp_valid_i = 1'b1; s_data_i = 32'h5555_AAAA; m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b1;
    #2;
    checks++;
    if ({m0_rsp_valid_o, m1_rsp_valid_o, s_rsp_ready_o} !== 3'b001 || m1_data_o !== 32'h0) begin
      failures++;
      $display("[TB] FAIL rstmid_drop got=%b/%h exp=001/00000000",
               {m0_rsp_valid_o, m1_rsp_valid_o, s_rsp_ready_o}, m1_data_o);
    end
    tick();
    s_rsp_valid_i = 1'b0;
    m1_req_valid_i = 1'b1; s_req_ready_i = 1'b1;
    #2;
    checks++;
    if (m1_req_ready_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_idle got=%b exp=1", m1_req_ready_o);
    end
    s_rsp_valid_i = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    tick();
    test_m1_only();
    test_contention();
    test_slow_slave();
    test_deassert();
    test_starvation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
